// File: rtl/sid_pkg.sv
// Shared widths, midscale and FSM state encoding for the SID sample-to-PDM output path.
package sid_pkg;
    localparam int SID_SAMPLE_W = 15;
    localparam int SID_MIDSCALE = 16384;
    localparam int SID_VOL_W    = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/sid_sd_mod.sv
// First-order sigma-delta modulator with tick divider; SID_PDM_DITHER_EN adds a 2-bit LFSR dither.
module sid_sd_mod
    import sid_pkg::*;
#(
    parameter int SAMPLE_W = SID_SAMPLE_W,
    parameter int CLK_DIV  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] level,
    output logic                pdm_out
);
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [SAMPLE_W-1:0] acc;
    logic [SAMPLE_W-1:0] mod_in;
    logic [SAMPLE_W:0]   sum;

    assign tick = (div_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? DIV_LAST : div_cnt - 1'b1;
        end
    end

`ifdef SID_PDM_DITHER_EN
    logic [15:0]       lfsr;
    logic [SAMPLE_W:0] dith_sum;

    // Dither can push the input past full scale; saturate instead of wrapping.
    assign dith_sum = {1'b0, level} + {{(SAMPLE_W - 1){1'b0}}, lfsr[1:0]};
    assign mod_in   = dith_sum[SAMPLE_W] ? '1 : dith_sum[SAMPLE_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (tick) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`else
    assign mod_in = level;
`endif

    assign sum = {1'b0, acc} + {1'b0, mod_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            pdm_out <= 1'b0;
        end else if (tick) begin
            acc     <= sum[SAMPLE_W-1:0];
            pdm_out <= sum[SAMPLE_W];
        end
    end
endmodule

// File: rtl/sid_pdm_out.sv
// SID output stage: sample capture, sequential volume multiply around midscale, PDM DAC.
// Optional LFSR dither in the modulator is enabled by defining SID_PDM_DITHER_EN.
//
// state | meaning
// IDLE  | waiting for a pending captured sample
// LOAD  | consume pending sample, centre it, clear product
// MUL   | one shift-add step per cycle; last step writes the clamped level
// DONE  | one-cycle drain before accepting the next sample
module sid_pdm_out
    import sid_pkg::*;
#(
    parameter int SAMPLE_W = SID_SAMPLE_W,
    parameter int CLK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SAMPLE_W-1:0]  sample_in,
    input  logic                 sample_ready,
    input  logic [SID_VOL_W-1:0] vol,
    output logic [SAMPLE_W-1:0]  level,
    output logic                 level_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 pdm_out
);
    localparam int                     PW    = SAMPLE_W + 5;
    localparam logic [SAMPLE_W-1:0]    MID   = SAMPLE_W'(2 ** (SAMPLE_W - 1));
    localparam logic signed [PW-1:0]   MID_P = PW'(2 ** (SAMPLE_W - 1));
    localparam logic signed [PW-1:0]   MAX_P = PW'(2 ** SAMPLE_W - 1);

    logic [SAMPLE_W-1:0]    cap_s;
    logic [SID_VOL_W-1:0]   cap_v;
    logic                   pending;
    logic [1:0]             state;
    logic [1:0]             step;
    logic signed [SAMPLE_W:0] mcand;
    logic [SID_VOL_W-1:0]   mplier;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   addend;
    logic signed [PW-1:0]   prod_next;
    logic signed [PW-1:0]   scaled;
    logic [SAMPLE_W-1:0]    level_next;
    logic                   consume;

    assign consume = (state == ST_LOAD);
    assign busy    = (state != ST_IDLE) || pending;

    always_comb begin
        addend     = mplier[step] ? (PW'(mcand) <<< step) : '0;
        prod_next  = prod + addend;
        scaled     = (prod_next >>> 4) + MID_P;
        level_next = scaled[SAMPLE_W-1:0];
        if (scaled < 0) begin
            level_next = '0;
        end else if (scaled > MAX_P) begin
            level_next = '1;
        end
    end

    // A strobe on the LOAD edge refills pending with the newer sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_s   <= '0;
            cap_v   <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (sample_ready) begin
                cap_s   <= sample_in;
                cap_v   <= vol;
                pending <= 1'b1;
                if (pending && !consume) begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

    // The final multiply step is folded into the level write so a sample lands six edges after capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            step        <= '0;
            mcand       <= '0;
            mplier      <= '0;
            prod        <= '0;
            level       <= MID;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    mcand  <= $signed({1'b0, cap_s} - {1'b0, MID});
                    mplier <= cap_v;
                    prod   <= '0;
                    step   <= '0;
                    state  <= ST_MUL;
                end
                ST_MUL: begin
                    prod <= prod_next;
                    step <= step + 1'b1;
                    if (step == 2'd3) begin
                        level       <= level_next;
                        level_valid <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sid_sd_mod #(
        .SAMPLE_W (SAMPLE_W),
        .CLK_DIV  (CLK_DIV)
    ) u_sd_mod (
        .clk     (clk),
        .rst     (rst),
        .level   (level),
        .pdm_out (pdm_out)
    );
endmodule

// File: tb/tb_sid_pdm_out.sv
// Self-checking bench for sid_pdm_out: arithmetic reference for volume scaling and PDM density.
module tb_sid_pdm_out;
    logic        clk;
    logic        rst;
    logic [14:0] sample_in;
    logic        sample_ready;
    logic [3:0]  vol;
    logic [14:0] level, level_4;
    logic        level_valid, level_valid_4;
    logic        busy, busy_4;
    logic        overrun, overrun_4;
    logic        pdm_out, pdm_out_4;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int n_valid = 0;
    int n_ovr = 0;

    sid_pdm_out #(.CLK_DIV(1)) u_dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_ready(sample_ready), .vol(vol),
        .level(level), .level_valid(level_valid), .busy(busy), .overrun(overrun), .pdm_out(pdm_out)
    );

    sid_pdm_out #(.CLK_DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_ready(sample_ready), .vol(vol),
        .level(level_4), .level_valid(level_valid_4), .busy(busy_4), .overrun(overrun_4),
        .pdm_out(pdm_out_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        if (level_valid) n_valid++;
        if (overrun) n_ovr++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        edge_n = 0;
        n_valid = 0;
        n_ovr = 0;
    endtask

    // Volume scaling: floor((sample - midscale) * vol / 16) + midscale, clamped to 15 bits.
    function automatic int ref_level(input int s, input int v);
        int d, q, r;
        d = (s - 16384) * v;
        q = (d >= 0) ? d / 16 : -((-d + 15) / 16);
        r = q + 16384;
        if (r < 0) r = 0;
        if (r > 32767) r = 32767;
        return r;
    endfunction

    task automatic mod_step(input int lvl, inout int acc, inout logic [15:0] lf, inout int b);
        int m;
        m = lvl;
`ifdef SID_PDM_DITHER_EN
        m = lvl + int'(lf[1:0]);
        if (m > 32767) m = 32767;
        lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
`endif
        b = ((acc + m) >= 32768) ? 1 : 0;
        acc = (acc + m) % 32768;
    endtask

    // Starts right after reset release with the silence level.
    task automatic check_pdm_bits(input int n);
        int a1, a4, b1, b4;
        logic [15:0] l1, l4;
        a1 = 0; a4 = 0; b1 = 0; b4 = 0;
        l1 = 16'hACE1; l4 = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            step();
            mod_step(16384, a1, l1, b1);
            if (edge_n % 4 == 1) mod_step(16384, a4, l4, b4);
            chk("pdm_d1", int'(pdm_out), b1);
            chk("pdm_d4", int'(pdm_out_4), b4);
        end
    endtask

    task automatic run_sample(input int s, input int v, input int exp_lvl);
        int lat;
        sample_in = 15'(s);
        vol = 4'(v);
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        sample_in = 15'($urandom);
        vol = 4'($urandom);
        n_valid = 0;
        n_ovr = 0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (level_valid && lat == 0) lat = i;
        end
        chk("latency", lat, 6);
        chk("valid_cnt", n_valid, 1);
        chk("level", int'(level), exp_lvl);
        chk("level_d4", int'(level_4), exp_lvl);
        chk("no_overrun", n_ovr, 0);
        chk("busy_after", int'(busy), 0);
    endtask

    typedef struct { int s; int v; int e; } vec_t;
    vec_t dir_vecs[5] = '{
        '{32767, 15, 31743},
        '{0, 15, 1024},
        '{0, 8, 8192},
        '{12345, 0, 16384},
        '{32767, 0, 16384}
    };

    initial begin
        int s, v, ones, chg4, bad4;
        logic prev4;
        rst = 1'b1;
        sample_ready = 1'b0;
        sample_in = '0;
        vol = '0;
        step();
        chk("rst_level", int'(level), 16384);
        chk("rst_valid", int'(level_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_pdm", int'(pdm_out), 0);
        chk("rst_busy", int'(busy), 0);
        do_reset();

        check_pdm_bits(24);
        chk("idle_level", int'(level), 16384);

        foreach (dir_vecs[i]) run_sample(dir_vecs[i].s, dir_vecs[i].v, dir_vecs[i].e);

        for (int i = 0; i < 20; i++) begin
            s = $urandom_range(0, 32767);
            v = $urandom_range(0, 15);
            run_sample(s, v, ref_level(s, v));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
        end

        // Back-to-back strobes: first sample is overwritten before it is consumed.
        sample_in = 15'd8192;
        vol = 4'd15;
        sample_ready = 1'b1;
        n_valid = 0;
        n_ovr = 0;
        step();
        sample_in = 15'd24576;
        step();
        sample_ready = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("ovr_cnt", n_ovr, 1);
        chk("ovr_valid_cnt", n_valid, 1);
        chk("ovr_level", int'(level), ref_level(24576, 15));
        chk("ovr_busy", int'(busy), 0);

        run_sample(25123, 15, 24576);
        ones = 0;
        chg4 = 0;
        bad4 = 0;
        prev4 = pdm_out_4;
        for (int i = 0; i < 32768; i++) begin
            step();
            ones += int'(pdm_out);
            if (pdm_out_4 != prev4) begin
                chg4++;
                if (edge_n % 4 != 1) bad4++;
            end
            prev4 = pdm_out_4;
        end
`ifndef SID_PDM_DITHER_EN
        chk("density", ones, 24576);
`endif
        chk("d4_off_tick_changes", bad4, 0);
        chk("d4_toggles", int'(chg4 > 0), 1);

        // Reset while the multiplier is mid-sample.
        sample_in = 15'd30000;
        vol = 4'd15;
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_level", int'(level), 16384);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(level_valid), 0);
        chk("midrst_pdm", int'(pdm_out), 0);
        step();
        rst = 1'b0;
        edge_n = 0;
        n_valid = 0;
        check_pdm_bits(12);
        chk("midrst_no_valid", n_valid, 0);
        chk("midrst_busy_after", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
